// File: rtl/uart_frame_decoder.sv
// Frame decoder behind the UART receiver: 55 AA LEN payload CSUM, payload buffered until the XOR checksum verifies,
// then replayed on a valid/ready byte stream while the receiver is throttled via rx_en_sig.
module uart_frame_decoder #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_en_sig,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_LEN, S_PAYLOAD, S_CSUM, S_OUTPUT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   len_q, len_d, idx_q, idx_d, rd_q, rd_d, rd_nx;
  logic [7:0]      csum_q, csum_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            rx_en_q, rx_en_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0]      out_data_q, out_data_d, frame_len_q, frame_len_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            buf_we, tmo_active, tmo_hit;
  logic [7:0]      buf_q [MAX_LEN];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    csum_d      = csum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frame_len_d = frame_len_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    rd_nx       = rd_q + IW'(1);

    tmo_active = (state_q == S_HDR2) || (state_q == S_LEN) ||
                 (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    tmo_d      = (tmo_active && !rx_done) ? tmo_q + CW'(1) : '0;
    // A byte in the same cycle as the final count takes priority over the abort.
    tmo_hit    = tmo_active && !rx_done && (tmo_q == CW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: if (rx_done && rx_data == 8'h55) state_d = S_HDR2;
      S_HDR2: if (rx_done) begin
        if (rx_data == 8'hAA)      state_d = S_LEN;
        else if (rx_data != 8'h55) state_d = S_IDLE;
      end
      S_LEN: if (rx_done) begin
        if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end else begin
          len_d   = rx_data[IW-1:0];
          idx_d   = '0;
          csum_d  = rx_data;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (rx_done) begin
        buf_we = 1'b1;
        idx_d  = idx_q + IW'(1);
        csum_d = csum_q ^ rx_data;
        if (idx_q == len_q - IW'(1)) state_d = S_CSUM;
      end
      S_CSUM: if (rx_done) begin
        if (rx_data == csum_q) begin
          state_d     = S_OUTPUT;
          rd_d        = '0;
          out_valid_d = 1'b1;
          out_data_d  = buf_q[0];
          out_last_d  = (len_q == IW'(1));
          frame_len_d = 8'(len_q);
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = S_IDLE;
        end
      end
      S_OUTPUT: if (out_ready) begin
        if (out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rd_d       = rd_nx;
          out_data_d = buf_q[rd_nx[AW-1:0]];
          out_last_d = (rd_nx == len_q - IW'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
      state_d    = S_IDLE;
    end

    rx_en_d = (state_d != S_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      rx_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frame_len_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      rx_en_q     <= rx_en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frame_len_q <= frame_len_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign rx_en_sig = rx_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_len = frame_len_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: directed frames plus random traffic, scored against a stream-level frame parser.
module tb_uart_frame_decoder;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0, rst = 1'b1, rx_done = 1'b0, out_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_en_sig, out_valid, out_last, err;
  logic [7:0] out_data, frame_len;
  logic [1:0] err_code;

  uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .rx_en_sig(rx_en_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_len(frame_len), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0, nfail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] d; logic l; logic [7:0] n; } beat_t;
  typedef struct { logic [1:0] code; int at; } errx_t;

  logic [7:0] pend[$];
  beat_t      exp_q[$];
  errx_t      exp_err[$];
  int         last_drv = 0;

  // Reference: the bytes since the last resolved frame, trimmed until they start with 55 AA (or a lone trailing 55).
  function automatic void model_byte(input logic [7:0] b, input int c);
    pend.push_back(b);
    while (pend.size() > 0 && !(pend[0] == 8'h55 && (pend.size() == 1 || pend[1] == 8'hAA)))
      void'(pend.pop_front());
    if (pend.size() >= 3) begin
      int n;
      logic [7:0] x;
      n = int'(pend[2]);
      if (n == 0 || n > MAX_LEN) begin
        exp_err.push_back('{2'd1, c + 1});
        pend.delete();
      end else if (pend.size() == n + 4) begin
        x = 8'h00;
        for (int i = 2; i < n + 3; i++) x ^= pend[i];
        if (x == pend[n+3])
          for (int i = 0; i < n; i++) exp_q.push_back('{pend[3+i], (i == n - 1), 8'(n)});
        else
          exp_err.push_back('{2'd2, c + 1});
        pend.delete();
      end
    end
  endfunction

  function automatic void expect_timeout();
    if (pend.size() > 0) begin
      exp_err.push_back('{2'd3, last_drv + 1 + TIMEOUT});
      pend.delete();
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_en_sig && n < 200) begin idle(1); n++; end
    if (n >= 200) check("rx_en_wait", 32'(rx_en_sig), 32'd1);
    rx_done = 1'b1;
    rx_data = b;
    last_drv = cyc;
    model_byte(b, cyc);
    idle(1);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  logic [7:0] seq[$];
  task automatic send_seq(input int maxgap);
    foreach (seq[i]) begin
      send_byte(seq[i]);
      idle(maxgap == 0 ? 0 : $urandom_range(0, maxgap));
    end
  endtask

  int rdy_mode = 0, pidx = 0;
  logic [0:4] pat = 5'b10011;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && pidx < 5) begin out_ready = pat[pidx]; pidx++; end
        else out_ready = 1'b1;
      end
    endcase
  end

  logic        stall = 1'b0;
  logic [31:0] hold_v = '0;
  beat_t       eb;
  errx_t       ee;
  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) check("hold", 32'({out_valid, out_last, frame_len, out_data}), hold_v);
      stall  = out_valid && !out_ready;
      hold_v = 32'({out_valid, out_last, frame_len, out_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_unexp", 32'(out_valid), 32'd0);
        else begin
          eb = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(eb.d));
          check("out_last", 32'(out_last), 32'(eb.l));
          check("frame_len", 32'(frame_len), 32'(eb.n));
        end
      end
      if (err) begin
        if (exp_err.size() == 0) check("err_unexp", 32'(err), 32'd0);
        else begin
          ee = exp_err.pop_front();
          check("err_code", 32'(err_code), 32'(ee.code));
          check("err_cycle", cyc, ee.at);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_en"}, 32'(rx_en_sig), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    int lo, w, kind, n;
    logic [7:0] x, b;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    idle(1);
    check("rx_en_after_rst", 32'(rx_en_sig), 32'd1);

    seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(0);
    lo = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rx_en_sig) lo++;
      idle(1);
    end
    check("rx_en_low_cycles", lo, 3);

    seq = '{8'h55, 8'hAA, 8'h02, 8'hAB, 8'hCD, 8'h00};
    send_seq(1);
    idle(5);
    seq = '{8'h55, 8'hAA, 8'h00};
    send_seq(0);
    seq = '{8'h55, 8'hAA, 8'h11};
    send_seq(0);
    seq = '{8'h55, 8'hAA, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    send_seq(2);
    idle(5);
    seq = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    send_seq(1);
    idle(10);

    seq = '{8'h55, 8'hAA, 8'h02, 8'h10};
    send_seq(0);
    expect_timeout();
    idle(TIMEOUT + 5);
    check("err_code_held", 32'(err_code), 32'd3);
    send_seq(0);
    idle(TIMEOUT - 1);
    send_byte(8'h20);
    send_byte(8'h32);
    idle(10);

    rdy_mode = 2;
    pidx = 0;
    seq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(0);
    idle(10);
    check("ready_pattern_used", pidx, 5);
    rdy_mode = 0;

    seq = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
    send_seq(0);
    rst = 1'b1;
    idle(1);
    check_reset_vals("midrst");
    pend.delete();
    rst = 1'b0;
    idle(1);
    check("rx_en_after_midrst", 32'(rx_en_sig), 32'd1);
    seq = '{8'h55, 8'hAA, 8'h02, 8'hA0, 8'hB0, 8'h12};
    send_seq(1);
    idle(5);

    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      seq.delete();
      if (kind == 8) begin
        repeat ($urandom_range(1, 3)) seq.push_back(8'($urandom));
      end else begin
        if (kind == 9) seq.push_back(8'h55);
        seq.push_back(8'h55);
        seq.push_back(8'hAA);
        if (kind == 7) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        else n = $urandom_range(1, MAX_LEN);
        seq.push_back(8'(n));
        if (kind != 7) begin
          x = 8'(n);
          for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            seq.push_back(b);
            x ^= b;
          end
          seq.push_back(kind == 6 ? x ^ 8'($urandom_range(1, 255)) : x);
        end
      end
      send_seq(3);
    end

    expect_timeout();
    idle(TIMEOUT + 20);
    w = 0;
    while (exp_q.size() > 0 && w < 2000) begin idle(1); w++; end
    idle(5);
    check("exp_beats_left", exp_q.size(), 0);
    check("exp_errs_left", exp_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Receive-side frame decoder that sits directly downstream of the UART receiver. It consumes one byte per receiver completion pulse and recognises frames of the form 0x55, 0xAA, LEN, LEN payload bytes, CSUM. Payload is buffered until the checksum verifies, then replayed on a valid/ready byte stream. While the decoder is replaying, it throttles the receiver through its enable output.

## Interface
Parameters:
- MAX_LEN, default 16: largest legal LEN and the payload buffer depth, in bytes (1..255).
- TIMEOUT, default 20000: number of clk cycles without a byte, mid-frame, that aborts the frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_done  in  1  single-cycle pulse from the receiver; qualifies rx_data.
- rx_data  in  8  received byte; valid only while rx_done=1.
- rx_en_sig  out  1  receive enable to the receiver; high when the decoder accepts bytes.
- out_valid  out  1  payload byte available.
- out_ready  in  1  downstream accepts the byte; a transfer happens when out_valid & out_ready.
- out_data  out  8  payload byte.
- out_last  out  1  marks the final payload byte of the frame.
- frame_len  out  8  LEN of the frame being replayed; stable while out_valid=1.
- err  out  1  single-cycle pulse when a frame is discarded.
- err_code  out  2  cause of the latest discard: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout. Holds until the next err.

## Operation
States and transitions:
- IDLE: byte 0x55 → HDR2. Any other byte is ignored.
- HDR2:
  - 0xAA → LEN.
  - 0x55 → stay in HDR2 (resync).
  - Other → IDLE, with no err.
- LEN:
  - Byte of 0 or greater than MAX_LEN → err with err_code=1, then IDLE.
  - Otherwise latch len, clear the write index, set csum_acc = byte, → PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[idx], then idx++ and csum_acc ^= byte.
  - When idx reaches len → CSUM.
- CSUM:
  - Byte == csum_acc → OUTPUT with read index 0.
  - Otherwise → err with err_code=2, then IDLE. The buffer is discarded.
- OUTPUT:
  - Present buf[rd] on out_data. On each transfer, rd++.
  - The transfer where rd == len-1 carries out_last=1, and the state returns to IDLE.

Checksum and buffer rules:
- The checksum is the 8-bit XOR of LEN and all payload bytes. Headers are excluded.
- The buffer is MAX_LEN×8 registers or distributed RAM. Index width is clog2(MAX_LEN+1).

Enable and timeout:
- rx_en_sig is 1 in IDLE, HDR2, LEN, PAYLOAD and CSUM, and 0 in OUTPUT.
- A byte that arrives during OUTPUT is dropped silently.
- The timeout counter is active only in HDR2, LEN, PAYLOAD and CSUM.
  - It clears on every rx_done and on entry to these states.
  - When it reaches TIMEOUT, the decoder pulses err with err_code=3 and returns to IDLE.
  - If rx_done arrives in the same cycle that the count reaches TIMEOUT, the byte wins and the counter clears.

## Timing
- Reset values:
  - state IDLE
  - rx_en_sig 0, then 1 from the first cycle after rst deasserts
  - out_valid 0, out_data 0x00, out_last 0, frame_len 0x00
  - err 0, err_code 0
  - all indices, csum_acc and the timeout counter 0
- Every byte is consumed in the rx_done cycle, and the state updates on that edge.
- Latency:
  - out_valid rises on the edge that samples a matching CSUM byte, so it is visible in the next cycle.
  - rx_en_sig falls in that same cycle.
- Hold rule: out_data, out_last and frame_len are registered. They stay stable while out_valid=1 and out_ready=0. Bytes are never skipped or repeated.
- Throughput: with out_ready held at 1, one byte transfers per cycle. A frame of len bytes drains in len cycles.
- End of replay: after the out_last transfer, out_valid=0 and rx_en_sig=1 in the next cycle.
- err is a one-cycle pulse. It asserts in the cycle after the offending byte, or in the cycle after the timeout hit.
- A rst asserted mid-frame or mid-replay aborts immediately. The next cycle shows reset values, and no err is generated.

## Test plan
- Good frame: send 55 AA 03 11 22 33 03 with out_ready=1.
  - Required: out_data 11, 22, 33 on consecutive cycles, with out_last on 33 and frame_len=3.
  - Required: rx_en_sig low for exactly 3 cycles, and no err.
- Bad checksum: send 55 AA 02 AB CD 00 (the correct value is 64).
  - Required: err pulse with err_code=2, out_valid never asserts, and the state returns to IDLE.
- Bad length: send 55 AA 00, then separately 55 AA 11 with MAX_LEN=16.
  - Required: err with err_code=1 both times.
  - Required: a following good frame decodes correctly.
- Resync and noise: send 12 55 55 AA 01 7E 7F.
  - Required: a single-byte frame with out_data 7E and out_last=1, and no err.
- Timeout: send 55 AA 02 10, then no rx_done for TIMEOUT cycles.
  - Required: err with err_code=3 exactly TIMEOUT cycles after the 10 byte.
  - Also: a byte arriving in the timeout cycle must not cause err.
- Back-pressure and reset: use the good frame with out_ready toggling 1,0,0,1,1.
  - Required: data is held while ready=0, and the sequence is 11, 22, 33 intact.
  - Separately, assert rst during PAYLOAD. Required: reset values the next cycle, no err, and the next frame decodes.
